// File: rtl/text_buffer_ctrl_pkg.sv
// Shared definitions for the text buffer write controller and the text overlay:
// FSM encoding, fill character, text-box geometry and colour.
package text_buffer_ctrl_pkg;

  localparam int             TB_ADDR_W       = 8;
  localparam int             TB_CHAR_W       = 7;
  localparam int             TB_POS_W        = 12;
  localparam logic [6:0]     DEF_CLEAR_CHAR  = 7'h20;
  localparam int             RECT_WIDTH      = 128;
  localparam int             RECT_HEIGHT     = 64;
  localparam logic [11:0]    TEXT_COLOUR     = 12'hfff;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLEAR = 2'd2
  } tbc_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter: a lone request always wins, a tie goes to the
// client named by the pointer, and the pointer toggles on every accepted grant.
module rr_arbiter2 (
  input  logic       pclk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rr_reg <= 1'b0;
    end else if (accept) begin
      rr_reg <= ~rr_reg;
    end
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Write-side controller of the 256-cell text buffer: arbitrates two clients, runs a
// resumable bulk clear, and double-buffers the text-box position to vblank start.
module text_buffer_ctrl
  import text_buffer_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = TB_ADDR_W,
  parameter int                CHAR_W     = TB_CHAR_W,
  parameter int                POS_W      = TB_POS_W,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR = DEF_CLEAR_CHAR,
  parameter logic [POS_W-1:0]  DEF_X      = '0,
  parameter logic [POS_W-1:0]  DEF_Y      = '0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk_in,
  input  logic              clr_req,
  input  logic              cli0_valid,
  input  logic [ADDR_W-1:0] cli0_addr,
  input  logic [CHAR_W-1:0] cli0_data,
  output logic              cli0_ready,
  input  logic              cli1_valid,
  input  logic [ADDR_W-1:0] cli1_addr,
  input  logic [CHAR_W-1:0] cli1_data,
  output logic              cli1_ready,
  input  logic              pos_valid,
  input  logic [POS_W-1:0]  pos_x,
  input  logic [POS_W-1:0]  pos_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CHAR_W-1:0] wr_data,
  output logic [POS_W-1:0]  width_start,
  output logic [POS_W-1:0]  height_start,
  output logic              busy
);

  tbc_state_e        state_reg, state_next;
  logic              clr_pend_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic              pos_pend_reg;
  logic [POS_W-1:0]  pos_x_pend_reg, pos_y_pend_reg;
  logic              vblnk_d_reg;

  logic [1:0] grant;
  logic       serve_en, xfer, clear_wr, clear_last, vblnk_rise;

  assign serve_en   = (state_reg == ST_SERVE) & vblnk_in;
  assign xfer       = serve_en & (|grant);
  assign clear_wr   = (state_reg == ST_CLEAR) & vblnk_in;
  assign clear_last = clear_wr & (&clr_ptr_reg);
  assign vblnk_rise = vblnk_in & ~vblnk_d_reg;

  assign cli0_ready = serve_en & grant[0];
  assign cli1_ready = serve_en & grant[1];
  assign busy       = clr_pend_reg;

  rr_arbiter2 u_arb (
    .pclk   (pclk),
    .rst    (rst),
    .req    ({cli1_valid, cli0_valid}),
    .accept (xfer),
    .grant  (grant)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (vblnk_in) state_next = clr_pend_reg ? ST_CLEAR : ST_SERVE;
      end
      ST_SERVE: begin
        if (!vblnk_in)        state_next = ST_IDLE;
        else if (clr_pend_reg) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!vblnk_in)       state_next = ST_IDLE;
        else if (clear_last) state_next = ST_SERVE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // clr_ptr only advances on an actual clear write, so a vblank cut-off resumes in place
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clr_pend_reg <= 1'b0;
      clr_ptr_reg  <= '0;
    end else begin
      if (clear_last)   clr_pend_reg <= 1'b0;
      else if (clr_req) clr_pend_reg <= 1'b1;
      if (clear_wr)     clr_ptr_reg  <= clr_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (clear_wr) begin
      wr_en   <= 1'b1;
      wr_addr <= clr_ptr_reg;
      wr_data <= CLEAR_CHAR;
    end else if (xfer) begin
      wr_en   <= 1'b1;
      wr_addr <= grant[1] ? cli1_addr : cli0_addr;
      wr_data <= grant[1] ? cli1_data : cli0_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // A pulse arriving in the rise cycle itself bypasses the pending regs so it is not lost
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_d_reg    <= 1'b0;
      pos_pend_reg   <= 1'b0;
      pos_x_pend_reg <= '0;
      pos_y_pend_reg <= '0;
      width_start    <= DEF_X;
      height_start   <= DEF_Y;
    end else begin
      vblnk_d_reg <= vblnk_in;
      if (pos_valid) begin
        pos_x_pend_reg <= pos_x;
        pos_y_pend_reg <= pos_y;
        pos_pend_reg   <= 1'b1;
      end
      if (vblnk_rise && (pos_pend_reg || pos_valid)) begin
        width_start  <= pos_valid ? pos_x : pos_x_pend_reg;
        height_start <= pos_valid ? pos_y : pos_y_pend_reg;
        pos_pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl: per-cycle vector table for client arbitration,
// then hand-written sequences for bulk clear, resume, position update and reset.
module tb_text_buffer_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in, clr_req, pos_valid;
  logic        cli0_valid, cli1_valid, cli0_ready, cli1_ready;
  logic [7:0]  cli0_addr, cli1_addr, wr_addr;
  logic [6:0]  cli0_data, cli1_data, wr_data;
  logic [11:0] pos_x, pos_y, width_start, height_start;
  logic        wr_en, busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ptr = 0;
  int nwr;

  typedef struct {
    logic       vb;
    logic       v0; logic [7:0] a0; logic [6:0] d0;
    logic       v1; logic [7:0] a1; logic [6:0] d1;
    logic       r0; logic r1;
    logic       we; logic [7:0] wa; logic [6:0] wd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  text_buffer_ctrl dut (
    .pclk         (pclk),
    .rst          (rst),
    .vblnk_in     (vblnk_in),
    .clr_req      (clr_req),
    .cli0_valid   (cli0_valid),
    .cli0_addr    (cli0_addr),
    .cli0_data    (cli0_data),
    .cli0_ready   (cli0_ready),
    .cli1_valid   (cli1_valid),
    .cli1_addr    (cli1_addr),
    .cli1_data    (cli1_data),
    .cli1_ready   (cli1_ready),
    .pos_valid    (pos_valid),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .width_start  (width_start),
    .height_start (height_start),
    .busy         (busy)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic vb,
                               input logic v0, input logic [7:0] a0, input logic [6:0] d0,
                               input logic v1, input logic [7:0] a1, input logic [6:0] d1,
                               input logic r0, input logic r1,
                               input logic we, input logic [7:0] wa, input logic [6:0] wd);
    vec_t v;
    v.vb = vb; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  // One clock with no client traffic; outputs are valid on return (#1 after the edge)
  task automatic cyc(input logic vb, input logic cr, input logic pv,
                     input logic [11:0] px, input logic [11:0] py);
    @(negedge pclk);
    vblnk_in = vb; clr_req = cr; pos_valid = pv; pos_x = px; pos_y = py;
    cli0_valid = 1'b0; cli1_valid = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Runs n cycles at a fixed vblank level, checking every write as a clear write at exp_ptr
  task automatic run_cycles(input int n, input logic vb, input int req_at, input int probe_at,
                            output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      vblnk_in = vb; clr_req = (i == req_at); pos_valid = 1'b0;
      cli0_valid = (i == probe_at); cli0_addr = 8'h99; cli0_data = 7'h01; cli1_valid = 1'b0;
      #1;
      if (i == probe_at) chk("ready_during_clear", {31'd0, cli0_ready}, 32'd0);
      @(posedge pclk); #1;
      if (wr_en) begin
        chk("clear_addr", {24'd0, wr_addr}, exp_ptr & 32'hff);
        chk("clear_data", {25'd0, wr_data}, 32'h20);
        exp_ptr++;
        cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; vblnk_in = 1'b0; clr_req = 1'b0; pos_valid = 1'b0;
    pos_x = '0; pos_y = '0;
    cli0_valid = 1'b0; cli0_addr = '0; cli0_data = '0;
    cli1_valid = 1'b0; cli1_addr = '0; cli1_data = '0;

    //             vb  v0 a0     d0     v1 a1     d1     r0 r1 we wa     wd
    vecs[0]  = mkv(0,  1, 8'h00, 7'h41, 0, 8'h00, 7'h00, 0, 0, 0, 8'h00, 7'h00);
    vecs[1]  = mkv(1,  1, 8'h00, 7'h41, 0, 8'h00, 7'h00, 0, 0, 0, 8'h00, 7'h00);
    vecs[2]  = mkv(1,  1, 8'h00, 7'h41, 0, 8'h00, 7'h00, 1, 0, 1, 8'h00, 7'h41);
    vecs[3]  = mkv(1,  0, 8'h10, 7'h42, 1, 8'h20, 7'h43, 0, 1, 1, 8'h20, 7'h43);
    vecs[4]  = mkv(1,  1, 8'h10, 7'h42, 1, 8'h20, 7'h43, 1, 0, 1, 8'h10, 7'h42);
    vecs[5]  = mkv(1,  1, 8'h10, 7'h42, 1, 8'h20, 7'h43, 0, 1, 1, 8'h20, 7'h43);
    vecs[6]  = mkv(1,  1, 8'h10, 7'h42, 1, 8'h20, 7'h43, 1, 0, 1, 8'h10, 7'h42);
    vecs[7]  = mkv(1,  1, 8'h10, 7'h42, 1, 8'h20, 7'h43, 0, 1, 1, 8'h20, 7'h43);
    vecs[8]  = mkv(1,  0, 8'h11, 7'h11, 0, 8'h22, 7'h22, 0, 0, 0, 8'h20, 7'h43);
    vecs[9]  = mkv(1,  1, 8'h05, 7'h11, 0, 8'h22, 7'h22, 1, 0, 1, 8'h05, 7'h11);
    vecs[10] = mkv(1,  0, 8'h05, 7'h11, 1, 8'hff, 7'h7f, 0, 1, 1, 8'hff, 7'h7f);
    vecs[11] = mkv(0,  1, 8'h33, 7'h44, 0, 8'h00, 7'h00, 0, 0, 0, 8'hff, 7'h7f);
    vecs[12] = mkv(0,  1, 8'h33, 7'h44, 0, 8'h00, 7'h00, 0, 0, 0, 8'hff, 7'h7f);
    vecs[13] = mkv(1,  1, 8'h33, 7'h44, 0, 8'h00, 7'h00, 0, 0, 0, 8'hff, 7'h7f);
    vecs[14] = mkv(1,  1, 8'h33, 7'h44, 0, 8'h00, 7'h00, 1, 0, 1, 8'h33, 7'h44);
    vecs[15] = mkv(1,  1, 8'h01, 7'h02, 1, 8'h03, 7'h04, 0, 1, 1, 8'h03, 7'h04);

    // reset state
    repeat (2) @(negedge pclk);
    chk("rst_wr_en",  {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {25'd0, wr_data}, 32'd0);
    chk("rst_width",  {20'd0, width_start}, 32'd0);
    chk("rst_height", {20'd0, height_start}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // client arbitration table
    for (int i = 0; i < NV; i++) begin
      @(negedge pclk);
      vblnk_in = vecs[i].vb; clr_req = 1'b0; pos_valid = 1'b0;
      cli0_valid = vecs[i].v0; cli0_addr = vecs[i].a0; cli0_data = vecs[i].d0;
      cli1_valid = vecs[i].v1; cli1_addr = vecs[i].a1; cli1_data = vecs[i].d1;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, cli0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("v%0d_ready1", i), {31'd0, cli1_ready}, {31'd0, vecs[i].r1});
      @(posedge pclk); #1;
      chk($sformatf("v%0d_wr_en", i),   {31'd0, wr_en},   {31'd0, vecs[i].we});
      chk($sformatf("v%0d_wr_addr", i), {24'd0, wr_addr}, {24'd0, vecs[i].wa});
      chk($sformatf("v%0d_wr_data", i), {25'd0, wr_data}, {25'd0, vecs[i].wd});
      $display("vec %0d: ready=%b%b wr_en=%b addr=%h data=%h", i, cli1_ready, cli0_ready,
               wr_en, wr_addr, wr_data);
    end

    // clr_req together with a client write in SERVE: the write completes first
    @(negedge pclk);
    vblnk_in = 1'b1; clr_req = 1'b1; cli0_valid = 1'b1; cli0_addr = 8'h77; cli0_data = 7'h55;
    cli1_valid = 1'b0;
    #1;
    chk("clrreq_grant_ready", {31'd0, cli0_ready}, 32'd1);
    @(posedge pclk); #1;
    chk("clrreq_grant_wr_en", {31'd0, wr_en}, 32'd1);
    chk("clrreq_grant_addr", {24'd0, wr_addr}, 32'h77);
    chk("clrreq_grant_data", {25'd0, wr_data}, 32'h55);
    chk("clrreq_busy", {31'd0, busy}, 32'd1);

    // full clear in one long vblank; a second clr_req mid-clear must not restart it
    exp_ptr = 0;
    run_cycles(300, 1'b1, 50, 10, nwr);
    chk("full_clear_writes", nwr, 32'd256);
    chk("full_clear_busy_done", {31'd0, busy}, 32'd0);
    $display("full clear: %0d writes, busy=%b", nwr, busy);

    @(negedge pclk);
    vblnk_in = 1'b1; clr_req = 1'b0; cli0_valid = 1'b1; cli0_addr = 8'h12; cli0_data = 7'h34;
    #1;
    chk("post_clear_ready", {31'd0, cli0_ready}, 32'd1);
    @(posedge pclk); #1;
    chk("post_clear_addr", {24'd0, wr_addr}, 32'h12);
    chk("post_clear_data", {25'd0, wr_data}, 32'h34);

    // clear interrupted by end of vblank after 100 writes, resumed next vblank
    cyc(1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    exp_ptr = 0;
    run_cycles(101, 1'b1, -1, -1, nwr);
    chk("partial_first_writes", nwr, 32'd100);
    run_cycles(5, 1'b0, -1, -1, nwr);
    chk("partial_gap_writes", nwr, 32'd0);
    chk("partial_gap_busy", {31'd0, busy}, 32'd1);
    run_cycles(200, 1'b1, -1, -1, nwr);
    chk("partial_resume_writes", nwr, 32'd156);
    chk("partial_busy_done", {31'd0, busy}, 32'd0);
    $display("resumed clear: %0d writes, busy=%b", nwr, busy);

    // position update held until the vblank rising edge
    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    cyc(1'b0, 1'b0, 1'b1, 12'd200, 12'd96);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("pos_midframe_x", {20'd0, width_start}, 32'd0);
    chk("pos_midframe_y", {20'd0, height_start}, 32'd0);
    @(negedge pclk);
    vblnk_in = 1'b1; pos_valid = 1'b0;
    #1;
    chk("pos_rise_cycle_x", {20'd0, width_start}, 32'd0);
    @(posedge pclk); #1;
    chk("pos_applied_x", {20'd0, width_start}, 32'd200);
    chk("pos_applied_y", {20'd0, height_start}, 32'd96);
    $display("pos applied: x=%0d y=%0d", width_start, height_start);

    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    cyc(1'b0, 1'b0, 1'b1, 12'd10, 12'd20);
    cyc(1'b0, 1'b0, 1'b1, 12'd30, 12'd40);
    cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("pos_overwrite_x", {20'd0, width_start}, 32'd30);
    chk("pos_overwrite_y", {20'd0, height_start}, 32'd40);

    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    cyc(1'b1, 1'b0, 1'b1, 12'd55, 12'd66);
    chk("pos_same_cycle_x", {20'd0, width_start}, 32'd55);
    chk("pos_same_cycle_y", {20'd0, height_start}, 32'd66);

    cyc(1'b1, 1'b0, 1'b1, 12'd1, 12'd2);
    cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("pos_in_vblank_held", {20'd0, width_start}, 32'd55);
    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("pos_next_rise_x", {20'd0, width_start}, 32'd1);
    chk("pos_next_rise_y", {20'd0, height_start}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("pos_no_pend_x", {20'd0, width_start}, 32'd1);

    // asynchronous reset in the middle of a clear
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 12'd0);
    exp_ptr = 0;
    run_cycles(20, 1'b1, -1, -1, nwr);
    chk("midclear_writes", nwr, 32'd19);
    @(negedge pclk);
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_width", {20'd0, width_start}, 32'd0);
    chk("async_rst_addr", {24'd0, wr_addr}, 32'd0);
    @(negedge pclk);
    rst = 1'b0;
    run_cycles(5, 1'b1, -1, -1, nwr);
    chk("after_rst_no_writes", nwr, 32'd0);
    chk("after_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
